// File: rtl/matrix_reader.sv
// matrix_reader: read-side sequencer for the CPSD coefficient memory.
// Walks all (L+1)x(L+1) coefficients in row- or column-major order,
// drives the memory address and streams each word on a valid/ready port
// tagged with its row/column and end-of-sweep flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; address bus parked at 0
// FETCH | addressing the current element, loading it into the output slot
// DRAIN | final element loaded, waiting for its handshake
// FIN   | one-cycle done pulse, then back to IDLE
module matrix_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 6,
    localparam int IW        = ((L + 1) > 1) ? $clog2(L + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  col_major,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IW-1:0]         m_row,
    output logic [IW-1:0]         m_col,
    output logic                  m_last_col,
    output logic                  m_last
);

    localparam int                    N     = L + 1;
    localparam logic [IW-1:0]         L_IDX = IW'(L);
    localparam logic [DATA_WIDTH-1:0] N_W   = DATA_WIDTH'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          mode;
    logic [IW-1:0] i_cnt;
    logic [IW-1:0] j_cnt;
    logic [IW-1:0] row_idx;
    logic [IW-1:0] col_idx;
    logic          j_wrap;
    logic          is_final;
    logic          start_acc;
    logic          load;
    logic          accept;

    // Map outer/inner counters onto matrix coordinates for the latched order.
    always_comb begin
        row_idx  = mode ? j_cnt : i_cnt;
        col_idx  = mode ? i_cnt : j_cnt;
        j_wrap   = (j_cnt == L_IDX);
        is_final = (i_cnt == L_IDX) && j_wrap;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nx  = state;
        start_acc = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = FETCH;
                end
            end
            FETCH: begin
                // The slot is free when empty or being emptied this cycle.
                if (!m_valid || m_ready) begin
                    load = 1'b1;
                    if (is_final) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    accept   = 1'b1;
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Status and memory address, all derived from registered state.
    always_comb begin
        busy   = (state != IDLE);
        done   = (state == FIN);
        mem_we = 1'b0;
        mem_a  = '0;
        if (state == FETCH) begin
            mem_a = DATA_WIDTH'(row_idx) * N_W + DATA_WIDTH'(col_idx);
        end
    end

    // State register; en low freezes it, which also stretches a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nx;
        end
    end

    // Sweep counters, order latch and the registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= 1'b0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_row      <= '0;
            m_col      <= '0;
            m_last_col <= 1'b0;
            m_last     <= 1'b0;
        end else if (en) begin
            if (start_acc) begin
                mode  <= col_major;
                i_cnt <= '0;
                j_cnt <= '0;
            end
            if (load) begin
                m_data     <= mem_rd;
                m_row      <= row_idx;
                m_col      <= col_idx;
                m_last_col <= j_wrap;
                m_last     <= is_final;
                m_valid    <= 1'b1;
                // Counters park on the final element rather than wrapping past L.
                if (!is_final) begin
                    if (j_wrap) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + IW'(1);
                    end else begin
                        j_cnt <= j_cnt + IW'(1);
                    end
                end
            end
            if (accept) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_reader.sv
// Scoreboard bench for matrix_reader: L=2 instance for the directed sweeps,
// default L=6 instance for the full-size sweep. Memory model: mem[a] = a+100.
module tb_matrix_reader;

    logic        clk = 1'b0;
    logic        rst, en, col_major;
    logic        start2, ready2, start6, ready6;
    logic        busy2, done2, we2, valid2, lc2, last2;
    logic        busy6, done6, we6, valid6, lc6, last6;
    logic [15:0] a2, rd2, data2, a6, rd6, data6;
    logic [1:0]  row2, col2;
    logic [2:0]  row6, col6;

    assign rd2 = a2 + 16'd100;
    assign rd6 = a6 + 16'd100;

    matrix_reader #(.DATA_WIDTH(16), .L(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .start(start2), .col_major(col_major),
        .busy(busy2), .done(done2), .mem_a(a2), .mem_we(we2), .mem_rd(rd2),
        .m_data(data2), .m_valid(valid2), .m_ready(ready2),
        .m_row(row2), .m_col(col2), .m_last_col(lc2), .m_last(last2)
    );

    matrix_reader dut6 (
        .clk(clk), .rst(rst), .en(en), .start(start6), .col_major(col_major),
        .busy(busy6), .done(done6), .mem_a(a6), .mem_we(we6), .mem_rd(rd6),
        .m_data(data6), .m_valid(valid6), .m_ready(ready6),
        .m_row(row6), .m_col(col6), .m_last_col(lc6), .m_last(last6)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int d;
        int r;
        int c;
        int lc;
        int last;
        int cy;
    } exp_t;

    exp_t q2[$];
    exp_t q6[$];
    exp_t e2, e6;

    // Hand-computed sweeps for L=2 with mem[a] = a+100.
    int rm_d[9] = '{100, 101, 102, 103, 104, 105, 106, 107, 108};
    int rm_r[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int rm_c[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int cm_d[9] = '{100, 103, 106, 101, 104, 107, 102, 105, 108};
    int cm_r[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int cm_c[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   popped   = 0;
    int   stalls   = 0;
    logic stall_prev = 1'b0;
    logic [15:0] held;
    logic bp_on = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic push2(input bit cm, input int count, input bit timed);
        for (int k = 0; k < count; k++) begin
            exp_t e;
            e.d    = cm ? cm_d[k] : rm_d[k];
            e.r    = cm ? cm_r[k] : rm_r[k];
            e.c    = cm ? cm_c[k] : rm_c[k];
            e.lc   = (k % 3 == 2) ? 1 : 0;
            e.last = (k == 8) ? 1 : 0;
            e.cy   = timed ? 2 + k : -1;
            q2.push_back(e);
        end
    endtask

    // Pulse start on the L=2 instance; returns at the negedge of cycle 1.
    task automatic do_start(input bit cm);
        @(posedge clk); #1;
        start2 = 1'b1;
        col_major = cm;
        t0 = cyc;
        @(negedge clk);
        chk("busy_before_start", busy2, 0);
        @(posedge clk); #1;
        start2 = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy2, 1);
    endtask

    task automatic wait_done(input string nm, input bit sel, input int base, input bit add);
        bit found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if ((sel ? done6 : done2) === 1'b1) begin
                found = 1'b1;
                chk(nm, cyc - t0, base + (add ? stalls : 0));
                chk({nm, "_busy"}, sel ? busy6 : busy2, 1);
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual no done within 300 cycles required done", nm);
        end else begin
            @(negedge clk);
            chk({nm, "_pulse_end"}, sel ? done6 : done2, 0);
            chk({nm, "_idle"}, sel ? busy6 : busy2, 0);
        end
        chk({nm, "_queue_empty"}, sel ? q6.size() : q2.size(), 0);
    endtask

    // Backpressure generator: flips m_ready every cycle while enabled.
    initial forever begin
        @(posedge clk); #1;
        if (bp_on) ready2 = ~ready2;
    end

    // Monitor for the L=2 instance: pops on every real handshake.
    always @(negedge clk) begin
        if (!rst && en) begin
            if (stall_prev) chk("stall_hold", data2, held);
            if (valid2 && ready2) begin
                if (q2.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_elem2: actual data %0d required no element", data2);
                end else begin
                    e2 = q2.pop_front();
                    chk("m_data", data2, e2.d);
                    chk("m_row", row2, e2.r);
                    chk("m_col", col2, e2.c);
                    chk("m_last_col", lc2, e2.lc);
                    chk("m_last", last2, e2.last);
                    if (e2.cy >= 0) chk("elem_cycle", cyc - t0, e2.cy);
                end
                popped++;
            end
            if (valid2 && !ready2) begin
                stalls++;
                stall_prev = 1'b1;
                held = data2;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Monitor for the L=6 instance.
    always @(negedge clk) begin
        if (!rst && en && valid6 && ready6) begin
            if (q6.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_elem6: actual data %0d required no element", data6);
            end else begin
                e6 = q6.pop_front();
                chk("l6_data", data6, e6.d);
                chk("l6_row", row6, e6.r);
                chk("l6_col", col6, e6.c);
                chk("l6_last_col", lc6, e6.lc);
                chk("l6_last", last6, e6.last);
                chk("l6_cycle", cyc - t0, e6.cy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] snap_d;
    logic [1:0]  snap_r;
    logic        snap_v;

    initial begin
        rst = 1'b1; en = 1'b1; col_major = 1'b0;
        start2 = 1'b0; start6 = 1'b0; ready2 = 1'b1; ready6 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", valid2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_mem_a", a2, 0);
        chk("rst_mem_we", we2, 0);
        chk("rst_data", data2, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Row-major, continuous ready.
        push2(1'b0, 9, 1'b1);
        do_start(1'b0);
        wait_done("rm_done", 1'b0, 11, 1'b0);

        // Column-major, continuous ready.
        push2(1'b1, 9, 1'b1);
        do_start(1'b1);
        wait_done("cm_done", 1'b0, 11, 1'b0);

        // Alternating backpressure: done slips by exactly the stall count.
        stalls = 0;
        push2(1'b0, 9, 1'b0);
        bp_on = 1'b1;
        do_start(1'b0);
        wait_done("bp_done", 1'b0, 11, 1'b1);
        chk("bp_stalls_seen", (stalls >= 4) ? 1 : 0, 1);
        bp_on = 1'b0;
        @(posedge clk); #1;
        ready2 = 1'b1;

        // Reset right after element 4 is accepted.
        popped = 0;
        push2(1'b0, 5, 1'b1);
        do_start(1'b0);
        for (int c = 0; c < 40 && popped < 5; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_reached_elem4", popped, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", valid2, 0);
        chk("mid_rst_data", data2, 0);
        chk("mid_rst_row", row2, 0);
        chk("mid_rst_col", col2, 0);
        chk("mid_rst_last_col", lc2, 0);
        chk("mid_rst_last", last2, 0);
        chk("mid_rst_busy", busy2, 0);
        chk("mid_rst_mem_a", a2, 0);
        for (int c = 0; c < 4; c++) begin
            chk("mid_rst_no_done", done2, 0);
            @(negedge clk);
        end
        chk("mid_rst_queue_empty", q2.size(), 0);
        push2(1'b0, 9, 1'b1);
        do_start(1'b0);
        wait_done("rst_fresh_done", 1'b0, 11, 1'b0);

        // en low for cycles 4..6; start/col_major poked while busy.
        push2(1'b0, 9, 1'b0);
        do_start(1'b0);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        snap_d = data2;
        snap_r = row2;
        snap_v = valid2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("en_freeze_data", data2, snap_d);
            chk("en_freeze_row", row2, snap_r);
            chk("en_freeze_valid", valid2, snap_v);
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b1;
        col_major = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_done("en_done", 1'b0, 14, 1'b0);
        col_major = 1'b0;

        // Default L=6 instance, 49-element row-major sweep.
        for (int k = 0; k < 49; k++) begin
            exp_t e;
            e.d    = 100 + k;
            e.r    = k / 7;
            e.c    = k % 7;
            e.lc   = (k % 7 == 6) ? 1 : 0;
            e.last = (k == 48) ? 1 : 0;
            e.cy   = 2 + k;
            q6.push_back(e);
        end
        @(posedge clk); #1;
        start6 = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start6 = 1'b0;
        repeat (48) @(posedge clk);
        @(negedge clk);
        chk("l6_last_mem_a", a6, 48);
        wait_done("l6_done", 1'b1, 51, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
